// File: rtl/mem_req_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arb_pkg
// Purpose  : Shared types for the memory request arbiter: arbiter FSM state
//            encoding, default-width channel request/response structs that
//            mirror the single-master mem_req/mem_data port shape, and a
//            helper that sizes channel-index fields.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_req_arb_pkg;

    // Arbiter FSM state, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int c_DEF_ADDR_W = 32;
    localparam int c_DEF_DATA_W = 128;

    // One channel's request, same field set as the memory-side request.
    typedef struct packed {
        logic                    rw;
        logic [c_DEF_ADDR_W-1:0] addr;
        logic [c_DEF_DATA_W-1:0] data;
        logic                    valid;
    } ch_req_t;

    // One channel's completion, same shape as mem_data plus an error flag.
    typedef struct packed {
        logic [c_DEF_DATA_W-1:0] data;
        logic                    ready;
        logic                    err;
    } ch_res_t;

    // Width of a channel index; a single channel still gets a 1-bit field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_req_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Returns the first asserted
//            request found searching upward from ptr with wrap-around.
// Ports    : req     - request vector, one bit per channel
//            ptr     - index searched first (must be < N_CH)
//            grant   - winning index (0 when nothing is requested)
//            any_req - at least one request bit is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import mem_req_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int ID_W = id_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant,
    output logic            any_req
);

    int              w_sum;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        grant   = '0;
        any_req = |req;
        w_sum   = 0;
        w_idx   = '0;
        // Scan from the farthest offset back to ptr itself so the requester
        // closest to ptr is the last (and therefore winning) assignment.
        for (int off = N_CH - 1; off >= 0; off--) begin
            w_sum = int'(ptr) + off;
            if (w_sum >= N_CH) begin
                w_sum = w_sum - N_CH;
            end
            w_idx = ID_W'(w_sum);
            if (req[w_idx]) begin
                grant = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arb
// Purpose  : N-channel round-robin arbiter multiplexing cache-side memory
//            requesters onto one valid/ready memory port. A channel holds its
//            request until a one-cycle ready pulse returns the read data.
// Ports    : clk, rst (async, active-low)
//            ch_req_valid/rw/addr/data - per-channel held requests
//            ch_res_ready/err          - one-hot completion / error pulses
//            ch_res_data               - broadcast read data
//            mem_req_valid/rw/addr/data, mem_data_ready/data - memory port
//            grant_id, busy            - arbitration status
// Config   : MEM_REQ_ARB_TIMEOUT_EN - when defined, a BUSY transaction that
//            sees no mem_data_ready for TIMEOUT_CYCLES cycles is aborted with
//            an error pulse. Undefined: BUSY waits forever, ch_res_err = 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arb
    import mem_req_arb_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            ch_req_valid,
    input  logic [N_CH-1:0]            ch_req_rw,
    input  logic [N_CH*ADDR_W-1:0]     ch_req_addr,
    input  logic [N_CH*DATA_W-1:0]     ch_req_data,
    output logic [N_CH-1:0]            ch_res_ready,
    output logic [N_CH-1:0]            ch_res_err,
    output logic [DATA_W-1:0]          ch_res_data,
    output logic                       mem_req_valid,
    output logic                       mem_req_rw,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [DATA_W-1:0]          mem_req_data,
    input  logic                       mem_data_ready,
    input  logic [DATA_W-1:0]          mem_data_data,
    output logic [id_width(N_CH)-1:0]  grant_id,
    output logic                       busy
);

    localparam int                 c_ID_W    = id_width(N_CH);
    localparam logic [c_ID_W-1:0]  c_LAST_ID = c_ID_W'(N_CH - 1);
    localparam logic [N_CH-1:0]    c_ONE     = N_CH'(1);

    arb_state_t          r_state;
    logic [c_ID_W-1:0]   r_ptr;
    logic [c_ID_W-1:0]   r_grant_id;
    logic                r_req_valid;
    logic                r_req_rw;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_data;
    logic [N_CH-1:0]     r_res_ready;
    logic [DATA_W-1:0]   r_res_data;
    logic                r_busy;

    logic [c_ID_W-1:0]   w_pick;
    logic                w_any_req;

`ifdef MEM_REQ_ARB_TIMEOUT_EN
    // Counter holds the number of completed BUSY cycles; expiry is checked on
    // the edge that closes cycle TIMEOUT_CYCLES, i.e. when it reads LAST.
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [c_CNT_W-1:0]  r_busy_cnt;
    logic [N_CH-1:0]     r_res_err;
`endif

    rr_pick #(
        .N_CH (N_CH),
        .ID_W (c_ID_W)
    ) u_rr_pick (
        .req     (ch_req_valid),
        .ptr     (r_ptr),
        .grant   (w_pick),
        .any_req (w_any_req)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_req_valid <= 1'b0;
            r_req_rw    <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_res_ready <= '0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
`ifdef MEM_REQ_ARB_TIMEOUT_EN
            r_busy_cnt  <= '0;
            r_res_err   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant_id  <= w_pick;
                        r_req_rw    <= ch_req_rw[w_pick];
                        r_req_addr  <= ch_req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
                        r_req_data  <= ch_req_data[int'(w_pick)*DATA_W +: DATA_W];
                        r_req_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= BUSY;
`ifdef MEM_REQ_ARB_TIMEOUT_EN
                        r_busy_cnt  <= '0;
`endif
                    end
                end

                BUSY: begin
                    // A real completion takes priority over a same-edge expiry.
                    if (mem_data_ready) begin
                        r_res_data  <= mem_data_data;
                        r_res_ready <= c_ONE << r_grant_id;
                        r_req_valid <= 1'b0;
                        r_state     <= RESP;
                    end
`ifdef MEM_REQ_ARB_TIMEOUT_EN
                    else if (r_busy_cnt == c_CNT_LAST) begin
                        r_res_data  <= '0;
                        r_res_ready <= c_ONE << r_grant_id;
                        r_res_err   <= c_ONE << r_grant_id;
                        r_req_valid <= 1'b0;
                        r_state     <= RESP;
                    end else begin
                        r_busy_cnt  <= r_busy_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    r_res_ready <= '0;
`ifdef MEM_REQ_ARB_TIMEOUT_EN
                    r_res_err   <= '0;
`endif
                    r_ptr       <= (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid = r_req_valid;
    assign mem_req_rw    = r_req_rw;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_data  = r_req_data;
    assign ch_res_ready  = r_res_ready;
    assign ch_res_data   = r_res_data;
    assign grant_id      = r_grant_id;
    assign busy          = r_busy;

`ifdef MEM_REQ_ARB_TIMEOUT_EN
    assign ch_res_err = r_res_err;
`else
    assign ch_res_err = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_arb
// Purpose  : Self-checking bench for mem_req_arb (N_CH=4, 32-bit address,
//            128-bit data). Directed scenarios plus a randomized run checked
//            against a transaction-level round-robin reference model.
// Config   : MEM_REQ_ARB_TIMEOUT_EN enables the timeout scenario and the
//            timeout rule in the reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_arb;

    localparam int N_CH           = 4;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 128;
    localparam int TIMEOUT_CYCLES = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        ch_req_valid;
    logic [N_CH-1:0]        ch_req_rw;
    logic [N_CH*ADDR_W-1:0] ch_req_addr;
    logic [N_CH*DATA_W-1:0] ch_req_data;
    logic [N_CH-1:0]        ch_res_ready;
    logic [N_CH-1:0]        ch_res_err;
    logic [DATA_W-1:0]      ch_res_data;
    logic                   mem_req_valid;
    logic                   mem_req_rw;
    logic [ADDR_W-1:0]      mem_req_addr;
    logic [DATA_W-1:0]      mem_req_data;
    logic                   mem_data_ready;
    logic [DATA_W-1:0]      mem_data_data;
    logic [1:0]             grant_id;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;

    mem_req_arb #(
        .N_CH           (N_CH),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_req_valid   (ch_req_valid),
        .ch_req_rw      (ch_req_rw),
        .ch_req_addr    (ch_req_addr),
        .ch_req_data    (ch_req_data),
        .ch_res_ready   (ch_res_ready),
        .ch_res_err     (ch_res_err),
        .ch_res_data    (ch_res_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_data_ready (mem_data_ready),
        .mem_data_data  (mem_data_data),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Outputs are observed 1 time unit after the rising edge; inputs are
    // changed at the same point and are sampled by the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_req(input int ch, input logic rw, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        ch_req_rw[ch]                    = rw;
        ch_req_addr[ch*ADDR_W +: ADDR_W] = a;
        ch_req_data[ch*DATA_W +: DATA_W] = d;
        ch_req_valid[ch]                 = 1'b1;
    endtask

    task automatic apply_reset();
        rst            = 1'b0;
        ch_req_valid   = '0;
        mem_data_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst            = 1'b0;
        ch_req_valid   = '0;
        ch_req_rw      = '0;
        ch_req_addr    = '0;
        ch_req_data    = '0;
        mem_data_ready = 1'b0;
        mem_data_data  = '0;
        tick();
        tick();
        n_checks++; if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", mem_req_valid); end
        n_checks++; if ({mem_req_rw, mem_req_addr, mem_req_data} !== '0) begin n_errors++; $display("FAIL reset_mem_req: got rw=%b addr=%h data=%h want 0", mem_req_rw, mem_req_addr, mem_req_data); end
        n_checks++; if ({ch_res_ready, ch_res_err} !== 8'h00) begin n_errors++; $display("FAIL reset_res: got ready=%b err=%b want 0", ch_res_ready, ch_res_err); end
        n_checks++; if (ch_res_data !== '0) begin n_errors++; $display("FAIL reset_res_data: got %h want 0", ch_res_data); end
        n_checks++; if ({grant_id, busy} !== 3'b000) begin n_errors++; $display("FAIL reset_grant_busy: got grant=%0d busy=%b want 0/0", grant_id, busy); end
        rst = 1'b1;
        tick();
        n_checks++; if ({mem_req_valid, busy} !== 2'b00) begin n_errors++; $display("FAIL reset_release_idle: got valid=%b busy=%b want 0/0", mem_req_valid, busy); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single_read();
        int vcnt;
        set_req(2, 1'b0, 32'h0000_1040, '0);
        tick();
        ch_req_valid = '0;   // request held by the arbiter; dropping early is harmless in BUSY
        ch_req_valid[2] = 1'b1;
        vcnt = mem_req_valid ? 1 : 0;
        n_checks++; if ({mem_req_valid, mem_req_rw, mem_req_addr} !== {1'b1, 1'b0, 32'h0000_1040}) begin n_errors++; $display("FAIL read_req: got valid=%b rw=%b addr=%h want 1/0/00001040", mem_req_valid, mem_req_rw, mem_req_addr); end
        n_checks++; if ({grant_id, busy} !== {2'd2, 1'b1}) begin n_errors++; $display("FAIL read_grant: got grant=%0d busy=%b want 2/1", grant_id, busy); end
        repeat (4) begin
            tick();
            if (mem_req_valid) vcnt++;
        end
        mem_data_ready = 1'b1;
        mem_data_data  = {16{8'hA5}};
        tick();
        mem_data_ready = 1'b0;
        ch_req_valid   = '0;
        n_checks++; if (vcnt !== 5) begin n_errors++; $display("FAIL read_valid_len: got %0d want 5", vcnt); end
        n_checks++; if ({mem_req_valid, ch_res_ready} !== {1'b0, 4'b0100}) begin n_errors++; $display("FAIL read_ready: got valid=%b ready=%b want 0/0100", mem_req_valid, ch_res_ready); end
        n_checks++; if (ch_res_data !== {16{8'hA5}}) begin n_errors++; $display("FAIL read_data: got %h want a5..a5", ch_res_data); end
        tick();
        n_checks++; if ({ch_res_ready, busy} !== 5'b0) begin n_errors++; $display("FAIL read_pulse_len: got ready=%b busy=%b want 0/0", ch_res_ready, busy); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_spurious_ready();
        mem_data_ready = 1'b1;
        mem_data_data  = rand_data();
        repeat (2) begin
            tick();
            n_checks++; if ({ch_res_ready, mem_req_valid, busy} !== 6'b0) begin n_errors++; $display("FAIL spurious_ready: got ready=%b valid=%b busy=%b want 0", ch_res_ready, mem_req_valid, busy); end
        end
        mem_data_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_fairness();
        int ngr, last_cyc, cyc;
        logic prev_v;
        apply_reset();
        for (int i = 0; i < N_CH; i++) set_req(i, 1'b0, ADDR_W'(32'h100 * (i + 1)), rand_data());
        ngr = 0; last_cyc = 0; cyc = 0; prev_v = 1'b0;
        while (ngr < 5 && cyc < 40) begin
            tick();
            cyc++;
            if (mem_req_valid && !prev_v) begin
                n_checks++; if (grant_id !== 2'(ngr % N_CH)) begin n_errors++; $display("FAIL fair_order[%0d]: got %0d want %0d", ngr, grant_id, ngr % N_CH); end
                if (ngr > 0) begin
                    n_checks++; if (cyc - last_cyc !== 3) begin n_errors++; $display("FAIL fair_period[%0d]: got %0d want 3", ngr, cyc - last_cyc); end
                end
                last_cyc = cyc;
                ngr++;
            end
            prev_v         = mem_req_valid;
            mem_data_ready = mem_req_valid;
            for (int i = 0; i < N_CH; i++) ch_req_valid[i] = !ch_res_ready[i];
        end
        n_checks++; if (ngr !== 5) begin n_errors++; $display("FAIL fair_grant_count: got %0d want 5", ngr); end
        ch_req_valid   = '0;
        mem_data_ready = 1'b0;
        repeat (3) tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_write_hold();
        int pulses;
        apply_reset();
        set_req(1, 1'b1, 32'h0000_2000, DATA_W'(16'h1234));
        tick();
        n_checks++; if ({mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, grant_id} !== {1'b1, 1'b1, 32'h0000_2000, DATA_W'(16'h1234), 2'd1}) begin n_errors++; $display("FAIL write_req: got valid=%b rw=%b addr=%h data=%h grant=%0d", mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, grant_id); end
        ch_req_addr[1*ADDR_W +: ADDR_W] = 32'h0000_3000;
        ch_req_data[1*DATA_W +: DATA_W] = DATA_W'(32'hDEAD_BEEF);
        ch_req_rw[1]                    = 1'b0;
        repeat (3) begin
            tick();
            n_checks++; if ({mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data} !== {1'b1, 1'b1, 32'h0000_2000, DATA_W'(16'h1234)}) begin n_errors++; $display("FAIL write_hold: got valid=%b rw=%b addr=%h data=%h want 1/1/00002000/1234", mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data); end
        end
        mem_data_ready = 1'b1;
        mem_data_data  = rand_data();
        pulses = 0;
        tick();
        mem_data_ready = 1'b0;
        n_checks++; if (ch_res_data !== mem_data_data) begin n_errors++; $display("FAIL write_res_data: got %h want %h", ch_res_data, mem_data_data); end
        if (ch_res_ready == 4'b0010) pulses++;
        ch_req_valid = '0;
        repeat (4) begin
            tick();
            if (ch_res_ready != 4'b0000) pulses++;
        end
        n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL write_pulse_once: got %0d pulses want 1", pulses); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_busy();
        int rdy_seen;
        apply_reset();
        set_req(0, 1'b0, 32'h0000_0500, '0);
        tick();
        n_checks++; if ({mem_req_valid, busy} !== 2'b11) begin n_errors++; $display("FAIL rstb_enter_busy: got valid=%b busy=%b want 1/1", mem_req_valid, busy); end
        rst = 1'b0;
        #1;
        n_checks++; if ({mem_req_valid, busy, ch_res_ready, grant_id, mem_req_addr} !== '0) begin n_errors++; $display("FAIL rstb_async_clear: got valid=%b busy=%b ready=%b grant=%0d addr=%h want 0", mem_req_valid, busy, ch_res_ready, grant_id, mem_req_addr); end
        ch_req_valid    = '0;
        set_req(3, 1'b1, 32'h0000_0700, rand_data());
        mem_data_ready  = 1'b1;
        rdy_seen = 0;
        repeat (2) begin
            tick();
            if (ch_res_ready != 4'b0000) rdy_seen++;
        end
        mem_data_ready = 1'b0;
        n_checks++; if (rdy_seen !== 0) begin n_errors++; $display("FAIL rstb_no_pulse: got %0d ready cycles want 0", rdy_seen); end
        rst = 1'b1;
        tick();
        n_checks++; if ({mem_req_valid, grant_id, mem_req_addr} !== {1'b1, 2'd3, 32'h0000_0700}) begin n_errors++; $display("FAIL rstb_grant3: got valid=%b grant=%0d addr=%h want 1/3/00000700", mem_req_valid, grant_id, mem_req_addr); end
        rst = 1'b0;
        set_req(1, 1'b0, 32'h0000_0600, '0);
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if ({mem_req_valid, grant_id} !== {1'b1, 2'd1}) begin n_errors++; $display("FAIL rstb_grant_from_ptr0: got valid=%b grant=%0d want 1/1", mem_req_valid, grant_id); end
        apply_reset();
    endtask

`ifdef MEM_REQ_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------------
    task automatic test_timeout();
        logic [DATA_W-1:0] md;
        apply_reset();
        set_req(2, 1'b0, 32'h40, '0);
        mem_data_data = rand_data() | DATA_W'(1);
        tick();
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++; if ({mem_req_valid, ch_res_ready} !== {1'b1, 4'b0000}) begin n_errors++; $display("FAIL to_wait[%0d]: got valid=%b ready=%b want 1/0000", k, mem_req_valid, ch_res_ready); end
        end
        tick();
        n_checks++; if ({mem_req_valid, ch_res_ready, ch_res_err} !== {1'b0, 4'b0100, 4'b0100}) begin n_errors++; $display("FAIL to_expire: got valid=%b ready=%b err=%b want 0/0100/0100", mem_req_valid, ch_res_ready, ch_res_err); end
        n_checks++; if (ch_res_data !== '0) begin n_errors++; $display("FAIL to_data_zero: got %h want 0", ch_res_data); end
        ch_req_valid = '0;
        tick();
        n_checks++; if ({ch_res_ready, ch_res_err} !== 8'h00) begin n_errors++; $display("FAIL to_pulse_len: got ready=%b err=%b want 0", ch_res_ready, ch_res_err); end
        set_req(2, 1'b0, 32'h40, '0);
        tick();
        repeat (7) tick();
        md             = rand_data();
        mem_data_ready = 1'b1;
        mem_data_data  = md;
        tick();
        mem_data_ready = 1'b0;
        ch_req_valid   = '0;
        n_checks++; if ({ch_res_ready, ch_res_err} !== {4'b0100, 4'b0000}) begin n_errors++; $display("FAIL to_ready_wins: got ready=%b err=%b want 0100/0000", ch_res_ready, ch_res_err); end
        n_checks++; if (ch_res_data !== md) begin n_errors++; $display("FAIL to_ready_wins_data: got %h want %h", ch_res_data, md); end
        tick();
    endtask
`endif

    // ------------------------------------------------------------------------
    // Randomized traffic. The reference model tracks one outstanding memory
    // transaction: which channel owns it, what it asked for, how long it has
    // waited, and the round-robin starting point for the next grant.
    task automatic test_random();
        int                mph, mptr, mg, tcnt, mcd, ntx;
        logic [N_CH-1:0]   v, exp_ready, exp_err;
        logic              mr, e_rw;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] md, e_wdata, e_rdata;
        apply_reset();
        mph = 0; mptr = 0; mg = 0; tcnt = 0; mcd = -1; ntx = 0;
        e_rw = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = ch_req_valid; mr = mem_data_ready; md = mem_data_data;
            exp_ready = '0; exp_err = '0;
            case (mph)
                0: if (v != '0) begin
                    for (int off = N_CH - 1; off >= 0; off--)
                        if (v[(mptr + off) % N_CH]) mg = (mptr + off) % N_CH;
                    e_rw    = ch_req_rw[mg];
                    e_addr  = ch_req_addr[mg*ADDR_W +: ADDR_W];
                    e_wdata = ch_req_data[mg*DATA_W +: DATA_W];
                    mph = 1; tcnt = 0;
                end
                1: if (mr) begin
                    exp_ready[mg] = 1'b1; e_rdata = md; mph = 2; ntx++;
                end else begin
                    tcnt++;
`ifdef MEM_REQ_ARB_TIMEOUT_EN
                    if (tcnt == TIMEOUT_CYCLES) begin
                        exp_ready[mg] = 1'b1; exp_err[mg] = 1'b1; e_rdata = '0; mph = 2; ntx++;
                    end
`endif
                end
                default: begin
                    mptr = (mg + 1) % N_CH; mph = 0;
                end
            endcase
            tick();
            n_checks++; if (mem_req_valid !== (mph == 1)) begin n_errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, mem_req_valid, mph == 1); end
            n_checks++; if (busy !== (mph != 0)) begin n_errors++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, mph != 0); end
            n_checks++; if ({ch_res_ready, ch_res_err} !== {exp_ready, exp_err}) begin n_errors++; $display("FAIL rnd_res@%0d: got ready=%b err=%b want %b/%b", cyc, ch_res_ready, ch_res_err, exp_ready, exp_err); end
            if (mph == 1) begin
                n_checks++; if ({grant_id, mem_req_rw, mem_req_addr, mem_req_data} !== {2'(mg), e_rw, e_addr, e_wdata}) begin n_errors++; $display("FAIL rnd_req@%0d: got g=%0d rw=%b addr=%h want g=%0d rw=%b addr=%h", cyc, grant_id, mem_req_rw, mem_req_addr, mg, e_rw, e_addr); end
            end
            if (exp_ready != '0) begin
                n_checks++; if (ch_res_data !== e_rdata) begin n_errors++; $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, ch_res_data, e_rdata); end
            end
            // Channel agents: drop after completion, otherwise maybe raise a new request.
            for (int i = 0; i < N_CH; i++) begin
                if (exp_ready[i]) ch_req_valid[i] = 1'b0;
                else if (!ch_req_valid[i] && ($urandom % 3 == 0))
                    set_req(i, 1'($urandom), $urandom, rand_data());
            end
            // Memory agent: random latency while busy, occasional stray ready otherwise.
            mem_data_data = rand_data();
            if (mph == 1) begin
                if (mcd < 0) mcd = int'($urandom % 5);
                if (mcd == 0) begin mem_data_ready = 1'b1; mcd = -1; end
                else begin mem_data_ready = 1'b0; mcd--; end
            end else begin
                mem_data_ready = ($urandom % 8 == 0);
            end
        end
        n_checks++; if (ntx < 20) begin n_errors++; $display("FAIL rnd_progress: got %0d transactions want >= 20", ntx); end
        ch_req_valid   = '0;
        mem_data_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_spurious_ready();
        test_fairness();
        test_write_hold();
        test_reset_busy();
`ifdef MEM_REQ_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_req_arb.md
# mem_req_arb

Parametrised N-channel arbiter that multiplexes several cache-side memory requesters onto the single valid/ready memory port defined in `cache_def`. Each channel holds a request (addr, data, rw, valid) until it receives a one-cycle ready pulse, which carries the read data. The block sits between the cache instances and the memory model/controller, and generalises the single-master memory port to N_CH channels and configurable widths.

## Interface
- N_CH, 4, number of requesting channels (≥1)
- ADDR_W, 32, address width
- DATA_W, 128, line data width
- TIMEOUT_CYCLES, 256, BUSY-cycle limit before abort (used only with the timeout macro; ≥2)
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-low
- ch_req_valid  in  N_CH  per-channel request valid
- ch_req_rw  in  N_CH  1 = write, 0 = read
- ch_req_addr  in  N_CH*ADDR_W  per-channel address; channel i at [i*ADDR_W +: ADDR_W]
- ch_req_data  in  N_CH*DATA_W  per-channel write data
- ch_res_ready  out  N_CH  one-cycle completion pulse, one-hot
- ch_res_err  out  N_CH  one-cycle error pulse, coincident with ready
- ch_res_data  out  DATA_W  read data, broadcast, valid while any ready bit is high
- mem_req_valid / mem_req_rw  out  1  memory-side request
- mem_req_addr  out  ADDR_W; mem_req_data  out  DATA_W
- mem_data_ready  in  1  memory completion pulse
- mem_data_data  in  DATA_W  memory read data
- grant_id  out  $clog2(N_CH) (min 1)  currently granted channel
- busy  out  1  high in BUSY and RESP

## Operation
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - If any ch_req_valid is set, pick the winner round-robin, searching from ptr upward with wrap.
  - Latch the winner's rw, addr, data and id into the output registers.
  - Next cycle: mem_req_valid=1, go to BUSY.
- BUSY:
  - Hold all mem_req_* outputs stable.
  - ch_req_* changes on the granted channel are ignored.
  - On mem_data_ready=1: register mem_data_data into ch_res_data, set ch_res_ready[grant_id]=1, drop mem_req_valid, go to RESP.
- RESP:
  - The ready pulse lasts exactly one cycle.
  - ptr ← (grant_id+1) mod N_CH.
  - Go to IDLE.
- The granting channel must drop valid in the cycle after it samples ready. IDLE samples valids at the end of its cycle, so a completed request is never re-granted.
- mem_data_ready in IDLE or RESP is ignored.
- For writes, ch_res_data still carries mem_data_data.
- Request valids that arrive while the arbiter is BUSY wait; there is no queueing beyond the channel's held request.
- N_CH=1 degenerates to a registered pass-through with the same FSM.

## Timing
- Reset (async assert, sync deassert expected):
  - state=IDLE, ptr=0, grant_id=0.
  - All outputs 0: mem_req_*, ch_res_*, busy.
  - Reset mid-transaction aborts without any response pulse.
- Request sampled at edge 0 → mem_req_valid high after edge 0.
- mem_data_ready sampled at edge k → ch_res_ready high in cycle k..k+1.
- Minimum per-transaction occupancy is 3 cycles: 1 BUSY + 1 RESP + 1 IDLE.
- Back-to-back requests from different channels see one idle cycle between mem_req_valid pulses.
- Fairness: with all channels requesting, grants rotate 0,1,…,N_CH-1,0.

## Configuration
- MEM_REQ_ARB_TIMEOUT_EN defined:
  - A BUSY-cycle counter starts at 0 on BUSY entry.
  - If it reaches TIMEOUT_CYCLES without mem_data_ready, drop mem_req_valid, pulse ch_res_ready and ch_res_err for the granted channel with ch_res_data=0, then go to RESP.
  - mem_data_ready on the same edge as expiry wins: normal completion, no error.
- MEM_REQ_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; ch_res_err is tied to 0.

## Structure
- `cache_def` gains:
  - state enum `arb_state_t` (IDLE, BUSY, RESP)
  - parametrisable channel request/response struct typedefs matching the existing mem_req/mem_data shape
- Sub-module `rr_pick`: combinational round-robin picker; inputs req vector and ptr, outputs grant index and any_req. Reusable by future arbiters.

## Test plan
- Single read, N_CH=4, ch2 addr 0x0000_1040; memory answers ready after 5 cycles with data 0xA5…A5 → mem_req_addr=0x1040, rw=0, valid for 5 cycles; ch_res_ready=4'b0100 for 1 cycle; ch_res_data=0xA5…A5.
- All four channels valid continuously, memory ready after 1 cycle → grant order 0,1,2,3,0; mem_req_valid period 3 cycles.
- Write on ch1 with data 0x1234; ch1 changes addr mid-BUSY → mem_req_addr/data unchanged until ready; ch_res_ready[1] pulses once.
- rst asserted in BUSY → all outputs 0 immediately, no ready pulse; after release, a pending ch3 request is granted first from ptr=0 only if ch0–ch2 are idle.
- With macro, TIMEOUT_CYCLES=8, no mem_data_ready → after 8 BUSY cycles ch_res_ready[g]=ch_res_err[g]=1, ch_res_data=0; with ready on cycle 8 → no error.
- Spurious mem_data_ready in IDLE → no ch_res_ready, state unchanged.
